// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int TMO_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle counter for the access watchdog; expired flags the last allowed cycle.
module mem_timeout_cnt import cpu_mem_pkg::*; #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ready handshake, pipeline stall and MEM/WB bubbles.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl import cpu_mem_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              wb_bubble,
  output logic              mem_err
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT out of range 2..65535");
  end

  state_e state;
  logic   access;

  assign access = mem_read | mem_write;

  // reset gates the IDLE term so a pending access cannot stall while held in reset
  assign stall     = reset & (((state == ST_IDLE) & access) | (state == ST_BUSY));
  assign wb_bubble = stall;

`ifdef MEM_TIMEOUT_EN
  logic tmo_expired;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (state == ST_DONE),
    .en      (state == ST_BUSY),
    .expired (tmo_expired)
  );
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
`ifdef MEM_TIMEOUT_EN
      mem_err    <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (access) begin
            dmem_addr  <= addr;
            dmem_wdata <= wdata;
            dmem_we    <= mem_write;   // store wins when both are set
            dmem_req   <= 1'b1;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ready) begin
            if (!dmem_we) load_data <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_expired) begin
            load_data <= '0;
            mem_err   <= 1'b1;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state     <= ST_DONE;
          end
`endif
        end
        // controls still on the EX/MEM register belong to the finished access
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; timeout checks run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  logic        clk, reset;
  logic        mem_read, mem_write, dmem_ready;
  logic [31:0] addr, wdata, dmem_rdata;
  logic        dmem_req, dmem_we, stall, wb_bubble, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, load_data;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .load_data  (load_data),
    .stall      (stall),
    .wb_bubble  (wb_bubble),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: arrival cycle, n BUSY cycles (ready on the n-th), DONE, then back to IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input int n,
                        input logic [31:0] rdat, input logic exp_we,
                        input logic [31:0] exp_load);
    int stalls;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    stalls = 0;
    #1;
    chk({tag, ".arrive_stall"}, 32'(stall), 32'd1);
    stalls += int'(stall);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == n) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdat;
      end
      stalls += int'(stall);
      if (i == 1) begin
        chk({tag, ".req"},   32'(dmem_req), 32'd1);
        chk({tag, ".we"},    32'(dmem_we), 32'(exp_we));
        chk({tag, ".addr"},  dmem_addr, a);
        chk({tag, ".wdata"}, dmem_wdata, wd);
      end
    end
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    chk({tag, ".done_stall"},  32'(stall), 32'd0);
    chk({tag, ".done_bubble"}, 32'(wb_bubble), 32'd0);
    chk({tag, ".done_req"},    32'(dmem_req), 32'd0);
    chk({tag, ".load_data"},   load_data, exp_load);
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(n + 1));
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    chk({tag, ".idle_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    addr = 32'h4; wdata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;

    // 1. reset state with a load pending
    #12;
    chk("rst.req",    32'(dmem_req), 32'd0);
    chk("rst.we",     32'(dmem_we), 32'd0);
    chk("rst.addr",   dmem_addr, 32'd0);
    chk("rst.wdata",  dmem_wdata, 32'd0);
    chk("rst.load",   load_data, 32'd0);
    chk("rst.err",    32'(mem_err), 32'd0);
    chk("rst.stall",  32'(stall), 32'd0);
    chk("rst.bubble", 32'(wb_bubble), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rel.stall", 32'(stall), 32'd1);
    tick();
    chk("rel.req",  32'(dmem_req), 32'd1);
    chk("rel.we",   32'(dmem_we), 32'd0);
    chk("rel.addr", dmem_addr, 32'h4);
    dmem_ready = 1'b1; dmem_rdata = 32'h0000_0011;
    tick();
    dmem_ready = 1'b0;
    chk("rel.done_stall", 32'(stall), 32'd0);
    chk("rel.load",       load_data, 32'h0000_0011);
    mem_read = 1'b0;
    tick();
    chk("rel.idle_stall", 32'(stall), 32'd0);

    // ready while IDLE must be ignored
    dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_ready = 1'b0;
    chk("idle_ready.load", load_data, 32'h0000_0011);
    chk("idle_ready.req",  32'(dmem_req), 32'd0);

    // 2. load, ready on 3rd BUSY cycle
    access("load", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    // 3. store, load_data holds
    access("store", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF);
    // 4. both set: store priority
    access("both", 1'b1, 1'b1, 32'h24, 32'hCAFE_0001, 2, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF);
    // 5. back-to-back loads: second arrives in the cycle after DONE
    access("ld_a", 1'b1, 1'b0, 32'h30, 32'h0, 1, 32'hAAAA_0000, 1'b0, 32'hAAAA_0000);
    access("ld_b", 1'b1, 1'b0, 32'h34, 32'h0, 2, 32'h5555_FFFF, 1'b0, 32'h5555_FFFF);

    // 6. ready never asserted
    mem_read = 1'b1; addr = 32'h40;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo.busy_stall", 32'(stall), 32'd1);
      chk("tmo.busy_err",   32'(mem_err), 32'd0);
    end
    tick();
    chk("tmo.err",   32'(mem_err), 32'd1);
    chk("tmo.load",  load_data, 32'd0);
    chk("tmo.req",   32'(dmem_req), 32'd0);
    chk("tmo.stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    tick();
    chk("tmo.err_pulse", 32'(mem_err), 32'd0);
    // ready on the expiry cycle wins
    mem_read = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h7777_1234;
    tick();
    dmem_ready = 1'b0; mem_read = 1'b0;
    chk("tmo_race.err",  32'(mem_err), 32'd0);
    chk("tmo_race.load", load_data, 32'h7777_1234);
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    chk("hang.stall", 32'(stall), 32'd1);
    chk("hang.req",   32'(dmem_req), 32'd1);
    chk("hang.err",   32'(mem_err), 32'd0);
    dmem_ready = 1'b1; dmem_rdata = 32'h7777_1234;
    tick();
    dmem_ready = 1'b0; mem_read = 1'b0;
    chk("hang.load", load_data, 32'h7777_1234);
    tick();
`endif

    // reset mid-BUSY drops req at once and captures nothing
    mem_read = 1'b1; addr = 32'h50;
    tick();
    chk("rstbusy.req_before", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'h9999_9999;
    #1;
    chk("rstbusy.req",   32'(dmem_req), 32'd0);
    chk("rstbusy.stall", 32'(stall), 32'd0);
    tick();
    chk("rstbusy.load",  load_data, 32'd0);
    dmem_ready = 1'b0; mem_read = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstbusy.idle", 32'(dmem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencing controller for the MEM stage's data-memory access. It turns per-instruction mem_read/mem_write controls from the EX/MEM register into a req/ready handshake with a multi-cycle data memory. While the access is in flight it stalls the front of the pipeline and inserts bubbles into the MEM/WB register. On completion it presents the captured load data to MEM/WB for one advancing cycle.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data word width
TIMEOUT, 16, max BUSY cycles before forced completion (used only with MEM_TIMEOUT_EN; legal range 2..65535)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read  in  1  EX/MEM control: instruction is a load
mem_write  in  1  EX/MEM control: instruction is a store
addr  in  ADDR_W  EX/MEM ALU result, used as the address
wdata  in  DATA_W  EX/MEM store data
dmem_ready  in  1  memory completion strobe
dmem_rdata  in  DATA_W  memory read data, valid with dmem_ready
dmem_req  out  1  request to memory, registered
dmem_we  out  1  write enable to memory, registered
dmem_addr  out  ADDR_W  latched address
dmem_wdata  out  DATA_W  latched store data
load_data  out  DATA_W  captured read data, feeds the MemDout input of MEM/WB
stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
wb_bubble  out  1  forces MEM/WB WB controls to 0 this cycle
mem_err  out  1  one-cycle pulse on timeout (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- States: IDLE, BUSY, DONE (2-bit, registered).
- Reset (reset=0, async): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, load_data=0, mem_err=0, timeout counter=0. stall and wb_bubble evaluate to 0 in IDLE when there is no access.
- stall = (IDLE & (mem_read|mem_write)) | BUSY. Combinational, so it is seen in the same cycle the access arrives.
- wb_bubble = stall.
- IDLE with an access present:
  - Latch addr into dmem_addr and wdata into dmem_wdata.
  - dmem_we <= mem_write; if both mem_read and mem_write are set, the write takes priority.
  - dmem_req <= 1; go to BUSY.
- IDLE with no access: remain in IDLE; outputs hold their values.
- BUSY:
  - dmem_req stays 1 and the counter increments.
  - On dmem_ready=1: load_data <= dmem_rdata if !dmem_we, else load_data holds; dmem_req <= 0, dmem_we <= 0; go to DONE.
  - dmem_ready while not in BUSY is ignored.
- DONE:
  - stall=0 and wb_bubble=0, so the pipeline advances and MEM/WB captures load_data.
  - The still-present mem_read/mem_write belong to the completed instruction and are ignored.
  - Next state is always IDLE; counter <= 0.
- Latency:
  - Load/store stalls for 1 + N cycles, where N = BUSY cycles until ready (minimum 1).
  - Minimum total of 3 cycles from access arrival to the advancing cycle.
- Back-to-back accesses: a new access arriving in the cycle after DONE starts normally from IDLE.
- Reset mid-BUSY: abandon immediately; dmem_req drops asynchronously and no data is captured.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - If the counter reaches TIMEOUT-1 in BUSY without dmem_ready: load_data <= 0, mem_err pulses 1 for one cycle, dmem_req <= 0, go to DONE.
  - If dmem_ready arrives in that same cycle, ready wins and there is no error.
- MEM_TIMEOUT_EN undefined:
  - BUSY waits indefinitely.
  - The counter logic is not instantiated and mem_err is constant 0.

Decomposition:
- Package cpu_mem_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - Default ADDR_W/DATA_W.
- One sub-module, mem_timeout_cnt: counter with clear/enable and an expiry output, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Reset low with mem_read=1 → all outputs 0, stall=0. Release reset → stall=1 in the same cycle; next cycle dmem_req=1 and dmem_we=0.
2. Load at addr=0x10, ready on 3rd BUSY cycle with rdata=0xDEADBEEF → stall high for 4 cycles, then DONE with load_data=0xDEADBEEF, stall=0 and wb_bubble=0 for 1 cycle.
3. Store addr=0x20, wdata=0x12345678, ready after 1 cycle → dmem_we=1 and dmem_wdata=0x12345678 during BUSY; load_data keeps its previous value.
4. mem_read=mem_write=1 → dmem_we=1, store takes priority.
5. Two consecutive loads (0xAAAA0000 then 0x5555FFFF) → each sees its own IDLE→BUSY→DONE sequence with correct data; no access is dropped or duplicated.
6. MEM_TIMEOUT_EN with TIMEOUT=4 and ready never asserted → after 4 BUSY cycles mem_err=1 for 1 cycle and load_data=0. Separately, reset asserted in BUSY → dmem_req=0 immediately.
